comparator_seq_ctrl: RTL and testbench

- Multi-cycle magnitude comparator for WIDTH-bit operands built on one shared comparator_4bit slice.
- Operands are accepted over a valid/ready handshake and walked one nibble per cycle, MSB nibble first.
- The walk stops at the first unequal nibble, or after the last nibble.
- The EQ/GT/LT result is returned over a second valid/ready handshake; the block sits between a requesting control unit and the slice.

---
 rtl/comparator_pkg.sv | 25 ++
 rtl/comparator_seq_ctrl_if.sv | 41 ++++
 rtl/comparator_4bit.sv | 22 ++
 rtl/comparator_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_comparator_seq_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/comparator_pkg.sv
//------------------------------------------------------------------------------
// Module : comparator_pkg
// Brief  : Shared types and constants for the sequential nibble comparator.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package comparator_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CMP  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Width of a counter that must hold the values 0..nib inclusive.
  function automatic int cnt_width(input int nib);
    return $clog2(nib + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/comparator_seq_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : comparator_seq_ctrl_if
// Brief  : Request/result handshake bundle between control unit and comparator.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface comparator_seq_ctrl_if
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = cnt_width(NIB);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_valid;
  logic             res_ready;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [CNT_W-1:0] nib_cnt;
  logic             busy;

  modport master (
    output start_valid, a, b, res_ready,
    input  start_ready, res_valid, eq, gt, lt, nib_cnt, busy
  );

  modport slave (
    input  start_valid, a, b, res_ready,
    output start_ready, res_valid, eq, gt, lt, nib_cnt, busy
  );

endinterface

`default_nettype wire

// File: rtl/comparator_4bit.sv
//------------------------------------------------------------------------------
// Module : comparator_4bit
// Brief  : Combinational unsigned 4-bit magnitude comparator slice.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module comparator_4bit (
  input  wire logic [3:0] i_a,
  input  wire logic [3:0] i_b,
  output logic            o_eq,
  output logic            o_gt,
  output logic            o_lt
);

  assign o_eq = (i_a == i_b);
  assign o_gt = (i_a >  i_b);
  assign o_lt = (i_a <  i_b);

endmodule

`default_nettype wire

// File: rtl/comparator_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module : comparator_seq_ctrl
// Brief  : Multi-cycle WIDTH-bit magnitude comparator walking one nibble per
//          cycle MSB first through a shared 4-bit slice. Define SIGNED_CMP_EN
//          for two's-complement comparison.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module comparator_seq_ctrl
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  comparator_seq_ctrl_if.slave bus
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = cnt_width(NIB);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIB - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDX_W-1:0] r_idx;
  logic             r_res_valid;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;
  logic             r_busy;
  logic [CNT_W-1:0] r_nib_cnt;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic                w_eq;
  logic                w_gt;
  logic                w_lt;

`ifdef SIGNED_CMP_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  logic [NIBBLE_W-1:0] w_sign_flip;
  assign w_sign_flip = {(r_idx == c_last_idx), {(NIBBLE_W-1){1'b0}}};
  assign w_a_nib     = r_a[r_idx*NIBBLE_W +: NIBBLE_W] ^ w_sign_flip;
  assign w_b_nib     = r_b[r_idx*NIBBLE_W +: NIBBLE_W] ^ w_sign_flip;
`else
  assign w_a_nib     = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
  assign w_b_nib     = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
`endif

  comparator_4bit u_slice (
    .i_a  (w_a_nib),
    .i_b  (w_b_nib),
    .o_eq (w_eq),
    .o_gt (w_gt),
    .o_lt (w_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_res_valid <= 1'b0;
      r_eq        <= 1'b0;
      r_gt        <= 1'b0;
      r_lt        <= 1'b0;
      r_busy      <= 1'b0;
      r_nib_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_valid) begin
            r_a       <= bus.a;
            r_b       <= bus.b;
            r_idx     <= c_last_idx;
            r_nib_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= CMP;
          end
        end
        CMP: begin
          r_nib_cnt <= r_nib_cnt + 1'b1;
          if (w_gt || w_lt) begin
            r_eq        <= 1'b0;
            r_gt        <= w_gt;
            r_lt        <= w_lt;
            r_res_valid <= 1'b1;
            r_state     <= DONE;
          end else if (w_eq && (r_idx == '0)) begin
            r_eq        <= 1'b1;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE: begin
          // Leaving via IDLE guarantees no accept in the consume cycle.
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = (r_state == IDLE);
  assign bus.res_valid   = r_res_valid;
  assign bus.eq          = r_eq;
  assign bus.gt          = r_gt;
  assign bus.lt          = r_lt;
  assign bus.nib_cnt     = r_nib_cnt;
  assign bus.busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_comparator_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_comparator_seq_ctrl
// Brief  : Self-checking bench for comparator_seq_ctrl (WIDTH=16).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_comparator_seq_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  comparator_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  comparator_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word compare; examined nibbles follow from the highest
  // differing bit of a^b.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output logic e, output logic g, output logic l, output int k);
    logic [WIDTH-1:0] d;
    int p;
    d = a ^ b;
`ifdef SIGNED_CMP_EN
    g = ($signed(a) > $signed(b));
    l = ($signed(a) < $signed(b));
`else
    g = (a > b);
    l = (a < b);
`endif
    e = (a == b);
    if (d == '0) begin
      k = NIB;
    end else begin
      p = 0;
      for (int i = 0; i < WIDTH; i++) if (d[i]) p = i;
      k = NIB - p / 4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input int hold, input bit pulse);
    logic e, g, l;
    int   k, cnt;
    model(a, b, e, g, l, k);
    chk("idle_start_ready", 32'(bus.start_ready), 32'd1);
    bus.a = a;
    bus.b = b;
    bus.start_valid = 1'b1;
    bus.res_ready = 1'b0;
    step();
    bus.start_valid = pulse;
    bus.a = ~a;
    bus.b = b ^ 16'h5A5A;
    chk("cmp_start_ready", 32'(bus.start_ready), 32'd0);
    chk("cmp_busy", 32'(bus.busy), 32'd1);
    chk("cmp_res_valid", 32'(bus.res_valid), 32'd0);
    cnt = 0;
    while (bus.res_valid !== 1'b1 && cnt <= NIB + 2) begin
      step();
      cnt++;
    end
    bus.start_valid = 1'b0;
    chk("latency", 32'(cnt), 32'(k));
    for (int h = 0; h <= hold; h++) begin
      chk("done_res_valid", 32'(bus.res_valid), 32'd1);
      chk("done_eq", 32'(bus.eq), 32'(e));
      chk("done_gt", 32'(bus.gt), 32'(g));
      chk("done_lt", 32'(bus.lt), 32'(l));
      chk("done_nib_cnt", 32'(bus.nib_cnt), 32'(k));
      chk("done_start_ready", 32'(bus.start_ready), 32'd0);
      chk("done_busy", 32'(bus.busy), 32'd1);
      if (h < hold) step();
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("post_res_valid", 32'(bus.res_valid), 32'd0);
    chk("post_start_ready", 32'(bus.start_ready), 32'd1);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_held_flags", 32'({bus.eq, bus.gt, bus.lt}), 32'({e, g, l}));
    step();
    chk("quiet_res_valid", 32'(bus.res_valid), 32'd0);
    chk("quiet_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb, mask;
    int j;
    bus.start_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #1;
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_flags", 32'({bus.eq, bus.gt, bus.lt}), 32'd0);
    chk("rst_nib_cnt", 32'(bus.nib_cnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    step();

    run(16'h1234, 16'h1234, 0, 1'b0);
    run(16'hA000, 16'h5FFF, 0, 1'b0);
    run(16'h0F35, 16'h0F3A, 0, 1'b1);
    run(16'h00FF, 16'h0000, 5, 1'b0);
    run(16'h8000, 16'h0001, 1, 1'b0);
    run(16'h7FFF, 16'hFFFF, 0, 1'b0);

    // Reset during the second CMP cycle.
    chk("rstm_start_ready", 32'(bus.start_ready), 32'd1);
    bus.a = 16'h1111;
    bus.b = 16'h1112;
    bus.start_valid = 1'b1;
    step();
    bus.start_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("rstm_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rstm_flags", 32'({bus.eq, bus.gt, bus.lt}), 32'd0);
    chk("rstm_nib_cnt", 32'(bus.nib_cnt), 32'd0);
    chk("rstm_busy", 32'(bus.busy), 32'd0);
    chk("rstm_start_ready", 32'(bus.start_ready), 32'd1);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < NIB + 3; c++) begin
      step();
      chk("rstm_no_result", 32'(bus.res_valid), 32'd0);
    end

    for (int n = 0; n < 24; n++) begin
      ra = WIDTH'($urandom);
      j  = $urandom_range(NIB, 0);
      if (j == NIB) begin
        rb = ra;
      end else begin
        mask = WIDTH'(($urandom_range(15, 1)) << (4 * j));
        mask = mask | (WIDTH'($urandom) & ((WIDTH'(1) << (4 * j)) - 1'b1));
        rb = ra ^ mask;
      end
      run(ra, rb, $urandom_range(2, 0), 1'($urandom_range(1, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
